// File: rtl/csa_pipe_if.sv
// Operand/result handshake bundle for csa_pipe.
// master = producer/consumer side, slave = adder side.
interface csa_pipe_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf
    );
endinterface

// File: rtl/csa_pipe.sv
// Two-stage carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 registers per-block sums for carry-in 0 and 1; stage 2 resolves the select chain.
module csa_pipe #(
    parameter int BLK  = 4,
    parameter int NBLK = 4
) (
    input  logic        clk,
    input  logic        rst,
    csa_pipe_if.slave   bus
);
    localparam logic [BLK:0] ONE = (BLK+1)'(1);

    logic [NBLK-1:0][BLK-1:0] a_blk, bb_blk;
    logic                     ci;
    logic                     msbc_z, msbc_o;
    logic                     s1_adv, s2_adv;

    logic                     v1_q, v1_d, v2_q, v2_d;
    logic [NBLK-1:0][BLK-1:0] sz_q, sz_d, so_q, so_d;
    logic [NBLK-1:0]          cz_q, cz_d, co_q, co_d;
    logic                     ci_q, ci_d, mz_q, mz_d, mo_q, mo_d;
    logic [NBLK-1:0][BLK-1:0] s_q, s_d;
    logic                     c_out_q, c_out_d, ovf_q, ovf_d;
    logic [NBLK:0]            cy;

    assign a_blk  = bus.a;
    assign bb_blk = bus.sub ? ~bus.b : bus.b;
    assign ci     = bus.sub | bus.c_in;

    // Carry into bit W-1 for each top-block carry-in; with a 1-bit block it is the carry-in itself.
    generate
        if (BLK == 1) begin : g_msb1
            assign msbc_z = 1'b0;
            assign msbc_o = 1'b1;
        end else begin : g_msbn
            localparam int L = BLK - 1;
            logic [L:0] lo;
            assign lo     = {1'b0, a_blk[NBLK-1][L-1:0]} + {1'b0, bb_blk[NBLK-1][L-1:0]};
            assign msbc_z = lo >  {1'b0, {L{1'b1}}};
            assign msbc_o = lo >= {1'b0, {L{1'b1}}};
        end
    endgenerate

    assign s2_adv       = !v2_q | bus.out_ready;
    assign s1_adv       = !v1_q | s2_adv;
    assign bus.in_ready = s1_adv;

    always_comb begin
        v1_d = s1_adv ? bus.in_valid : v1_q;
        sz_d = sz_q;
        so_d = so_q;
        cz_d = cz_q;
        co_d = co_q;
        ci_d = ci_q;
        mz_d = mz_q;
        mo_d = mo_q;
        if (s1_adv && bus.in_valid) begin
            for (int k = 0; k < NBLK; k++) begin
                {cz_d[k], sz_d[k]} = {1'b0, a_blk[k]} + {1'b0, bb_blk[k]};
                {co_d[k], so_d[k]} = {1'b0, a_blk[k]} + {1'b0, bb_blk[k]} + ONE;
            end
            ci_d = ci;
            mz_d = msbc_z;
            mo_d = msbc_o;
        end
    end

    always_comb begin
        cy    = '0;
        cy[0] = ci_q;
        for (int k = 0; k < NBLK; k++)
            cy[k+1] = cy[k] ? co_q[k] : cz_q[k];
    end

    always_comb begin
        v2_d    = s2_adv ? v1_q : v2_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        if (s2_adv && v1_q) begin
            for (int k = 0; k < NBLK; k++)
                s_d[k] = cy[k] ? so_q[k] : sz_q[k];
            c_out_d = cy[NBLK];
            ovf_d   = (cy[NBLK-1] ? mo_q : mz_q) ^ cy[NBLK];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            sz_q    <= '0;
            so_q    <= '0;
            cz_q    <= '0;
            co_q    <= '0;
            ci_q    <= 1'b0;
            mz_q    <= 1'b0;
            mo_q    <= 1'b0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            sz_q    <= sz_d;
            so_q    <= so_d;
            cz_q    <= cz_d;
            co_q    <= co_d;
            ci_q    <= ci_d;
            mz_q    <= mz_d;
            mo_q    <= mo_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_valid = v2_q;
    assign bus.s         = s_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_csa_pipe.sv
// Bench for csa_pipe: directed table and corner sequences on a 4x4 instance,
// plus randomized streams on four widths checked against an arithmetic model.
module tb_csa_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, rst_r;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    csa_pipe_if #(.W(16)) dif();
    csa_pipe #(.BLK(4), .NBLK(4)) dut (.clk(clk), .rst(rst_d), .bus(dif.slave));

    // Randomized streams, one per (BLK,NBLK) configuration.
    for (genvar g = 0; g < 4; g++) begin : rnd
        localparam int B  = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 3 : 8;
        localparam int N  = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 5 : 8;
        localparam int W  = B * N;
        localparam int NB = 10000;

        csa_pipe_if #(.W(W)) rif();
        csa_pipe #(.BLK(B), .NBLK(N)) u (.clk(clk), .rst(rst_r), .bus(rif.slave));

        logic [W+1:0] q[$];

        // {ovf, c_out, s} from plain integer arithmetic and the sign rule for overflow.
        function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin, input logic sb);
            logic [W-1:0] bb;
            logic         c0;
            logic [W:0]   full;
            logic         v;
            bb   = sb ? ~b : b;
            c0   = sb ? 1'b1 : cin;
            full = {1'b0, a} + {1'b0, bb} + (W+1)'(c0);
            v    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
            return {v, full[W], full[W-1:0]};
        endfunction

        initial begin
            int           acc;
            logic [63:0]  r1, r2;
            logic [W+1:0] e;
            acc           = 0;
            rif.in_valid  = 1'b0;
            rif.a         = '0;
            rif.b         = '0;
            rif.c_in      = 1'b0;
            rif.sub       = 1'b0;
            rif.out_ready = 1'b0;
            @(negedge clk);
            while (rst_r !== 1'b0) @(negedge clk);
            for (int cyc = 0; cyc < 40000 && (acc < NB || q.size() > 0); cyc++) begin
                @(negedge clk);
                r1            = {$urandom, $urandom};
                r2            = {$urandom, $urandom};
                rif.in_valid  = (acc < NB) && ($urandom_range(0, 9) < 7);
                rif.a         = r1[W-1:0];
                rif.b         = r2[W-1:0];
                rif.c_in      = 1'($urandom_range(0, 1));
                rif.sub       = 1'($urandom_range(0, 1));
                rif.out_ready = ($urandom_range(0, 9) < 7);
                #1;
                if (rif.out_valid && rif.out_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("rnd%0d spurious beat", g), 128'(1), 128'(0));
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("rnd%0d {ovf,c_out,s}", g),
                            128'({rif.ovf, rif.c_out, rif.s}), 128'(e));
                    end
                end
                if (rif.in_valid && rif.in_ready) begin
                    q.push_back(model(rif.a, rif.b, rif.c_in, rif.sub));
                    acc++;
                end
            end
            chk($sformatf("rnd%0d beats accepted", g), 128'(acc), 128'(NB));
            chk($sformatf("rnd%0d beats outstanding", g), 128'(q.size()), 128'(0));
            n_done++;
        end
    end

    typedef struct {
        string       nm;
        logic [15:0] a, b;
        logic        ci, sb;
        logic [15:0] s;
        logic        c, v;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int          sent, ngot;
        logic [15:0] got[4];
        logic        stable_ok, seen;

        tbl[0] = '{"add 00ff+0001",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{"add wrap",       16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{"add signed ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{"sub 5-7",        16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{"sub 8000-1",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{"add with cin",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[6] = '{"add neg ovf",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_d         = 1'b1;
        rst_r         = 1'b1;
        dif.in_valid  = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.c_in      = 1'b0;
        dif.sub       = 1'b0;
        dif.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("reset out_valid", 128'(dif.out_valid), 128'(0));
        chk("reset s",         128'(dif.s),         128'(0));
        chk("reset c_out",     128'(dif.c_out),     128'(0));
        chk("reset ovf",       128'(dif.ovf),       128'(0));
        @(negedge clk);
        rst_d = 1'b0;
        rst_r = 1'b0;
        #1;
        chk("post-reset in_ready", 128'(dif.in_ready), 128'(1));

        // Single beats: out_valid must appear on the second cycle after accept, not the first.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            dif.a         = tbl[i].a;
            dif.b         = tbl[i].b;
            dif.c_in      = tbl[i].ci;
            dif.sub       = tbl[i].sb;
            dif.in_valid  = 1'b1;
            dif.out_ready = 1'b1;
            @(negedge clk);
            dif.in_valid = 1'b0;
            #1;
            chk({tbl[i].nm, " early valid"}, 128'(dif.out_valid), 128'(0));
            @(negedge clk);
            #1;
            chk({tbl[i].nm, " valid"}, 128'(dif.out_valid), 128'(1));
            chk({tbl[i].nm, " {ovf,c_out,s}"}, 128'({dif.ovf, dif.c_out, dif.s}),
                128'({tbl[i].v, tbl[i].c, tbl[i].s}));
        end

        // Back-pressure: 4 beats n+n, consumer stalled for the first 5 cycles.
        sent      = 0;
        ngot      = 0;
        stable_ok = 1'b1;
        for (int cyc = 0; cyc < 40 && ngot < 4; cyc++) begin
            @(negedge clk);
            dif.out_ready = (cyc >= 5);
            dif.in_valid  = (sent < 4);
            dif.a         = 16'(sent + 1);
            dif.b         = 16'(sent + 1);
            dif.c_in      = 1'b0;
            dif.sub       = 1'b0;
            #1;
            if (dif.out_valid && !dif.out_ready && dif.s !== 16'h0002) stable_ok = 1'b0;
            if (cyc == 4) begin
                chk("bp beats accepted while stalled", 128'(sent), 128'(2));
                chk("bp in_ready while full", 128'(dif.in_ready), 128'(0));
                chk("bp out_valid while stalled", 128'(dif.out_valid), 128'(1));
            end
            if (dif.out_valid && dif.out_ready) begin
                got[ngot] = dif.s;
                ngot++;
            end
            if (dif.in_valid && dif.in_ready) sent++;
        end
        dif.in_valid = 1'b0;
        chk("bp s held during stall", 128'(stable_ok), 128'(1));
        chk("bp beats drained", 128'(ngot), 128'(4));
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp beat %0d", k), 128'(got[k]), 128'(2 * (k + 1)));

        // Reset with two beats in flight.
        @(negedge clk);
        dif.a         = 16'h1111;
        dif.b         = 16'h1111;
        dif.in_valid  = 1'b1;
        dif.out_ready = 1'b1;
        @(negedge clk);
        dif.a = 16'h2222;
        dif.b = 16'h2222;
        @(negedge clk);
        dif.in_valid = 1'b0;
        #1;
        chk("pre-rst s", 128'({dif.out_valid, dif.s}), 128'({1'b1, 16'h2222}));
        rst_d = 1'b1;
        #1;
        chk("mid-rst out_valid", 128'(dif.out_valid), 128'(0));
        chk("mid-rst s", 128'(dif.s), 128'(0));
        @(negedge clk);
        rst_d = 1'b0;
        #1;
        chk("after rst in_ready", 128'(dif.in_ready), 128'(1));
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (dif.out_valid) seen = 1'b1;
        end
        chk("stale beat after rst", 128'(seen), 128'(0));

        for (int i = 0; i < 80000 && n_done < 4; i++) @(negedge clk);
        chk("random streams finished", 128'(n_done), 128'(4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
